// File: rtl/cnn_conv_engine.sv
// rtl/cnn_conv_engine.sv - KxK valid-mode convolution engine over a byte memory (optional CNN_CONV_RELU_EN)
module cnn_conv_engine #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int K     = 3,
  parameter int AW    = 10,
  parameter int WBASE = 0,
  parameter int IBASE = 64,
  parameter int ACC_W = 20,
  parameter int SHIFT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    bias,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int KK_I = K * K;
  localparam int TW   = $clog2(KK_I + 1);
  localparam int KW   = $clog2(K + 1);
  localparam int CW   = $clog2(IMG_W + 1);
  localparam int RW   = $clog2(IMG_H + 1);

  localparam logic [TW-1:0] KK      = TW'(KK_I);
  localparam logic [TW-1:0] KK_LAST = TW'(KK_I - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(IMG_W - K);
  localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - K);

  localparam logic signed [ACC_W-1:0] Y_ZERO  = '0;
  localparam logic signed [ACC_W-1:0] Y_U8MAX = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] Y_S8MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Y_S8MIN = ACC_W'(-128);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_CONV   = 3'd2,
    S_EMIT   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Read-issue counters: tap index plus its (kx, ky) decomposition, and the
  // output window position (c, r).
  logic [TW-1:0] tap_q, tap_d;
  logic [KW-1:0] kx_q, kx_d;
  logic [KW-1:0] ky_q, ky_d;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;

  // Tracks the read issued last cycle, whose data is on mem_rdata now.
  logic          rvalid_q, rvalid_d;
  logic [TW-1:0] rtap_q, rtap_d;

  logic signed [7:0]       w_q [KK_I];
  logic signed [7:0]       w_d [KK_I];
  logic signed [7:0]       bias_q, bias_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [AW-1:0] addr_q, addr_d;

  logic                    issue;
  logic                    hs;
  logic                    last_ret;
  logic [AW-1:0]           issue_addr;
  logic signed [16:0]      pix_ext;
  logic signed [16:0]      w_ext;
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] y_full;
  logic [7:0]              y_sat;

  assign hs       = out_valid_q & out_ready;
  assign last_ret = rvalid_q && (rtap_q == KK_LAST);

  // Returning pixel times its weight; the final tap's sum is folded straight
  // into the result so out_valid rises the cycle after the last return.
  always_comb begin
    pix_ext = {9'd0, mem_rdata};
    w_ext   = {{9{w_q[rtap_q][7]}}, w_q[rtap_q]};
    prod    = pix_ext * w_ext;
    acc_sum = acc_q + {{(ACC_W-17){prod[16]}}, prod};
    biased  = acc_sum + {{(ACC_W-8){bias_q[7]}}, bias_q};
    y_full  = biased >>> SHIFT;
  end

  // Output activation: ReLU with unsigned clamp, or signed 8-bit clamp.
  always_comb begin
    y_sat = y_full[7:0];
`ifdef CNN_CONV_RELU_EN
    if (y_full < Y_ZERO) begin
      y_sat = 8'h00;
    end else if (y_full > Y_U8MAX) begin
      y_sat = 8'hFF;
    end
`else
    if (y_full < Y_S8MIN) begin
      y_sat = 8'h80;
    end else if (y_full > Y_S8MAX) begin
      y_sat = 8'h7F;
    end
`endif
  end

  // Address of the read being issued this cycle (weight tap or image tap).
  always_comb begin
    if (state_q == S_LOAD_W) begin
      issue_addr = AW'(WBASE + int'(tap_q));
    end else begin
      issue_addr = AW'(IBASE + (int'(r_q) + int'(ky_q)) * IMG_W + int'(c_q) + int'(kx_q));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_W;
      S_LOAD_W: if (last_ret) state_d = S_CONV;
      S_CONV:   if (last_ret) state_d = S_EMIT;
      S_EMIT:   if (hs) state_d = out_last_q ? S_FIN : S_CONV;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode; mem_addr holds the last issued address between reads.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = addr_q;
    issue     = 1'b0;
    out_data  = out_data_q;
    out_valid = out_valid_q;
    out_last  = out_last_q;
    case (state_q)
      S_LOAD_W, S_CONV: begin
        busy = 1'b1;
        if (tap_q < KK) begin
          issue    = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = issue_addr;
        end
      end
      S_EMIT:  busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: counters, weight capture, accumulate, result.
  always_comb begin
    tap_d       = tap_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    c_d         = c_q;
    r_d         = r_q;
    rvalid_d    = issue;
    rtap_d      = tap_q;
    w_d         = w_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    addr_d      = mem_addr;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bias_d = bias;
          tap_d  = '0;
          kx_d   = '0;
          ky_d   = '0;
          c_d    = '0;
          r_d    = '0;
          acc_d  = '0;
        end
      end
      S_LOAD_W: begin
        if (issue) tap_d = tap_q + TW'(1);
        if (rvalid_q) w_d[rtap_q] = mem_rdata;
        if (last_ret) tap_d = '0;
      end
      S_CONV: begin
        if (issue) begin
          tap_d = tap_q + TW'(1);
          if (kx_q == K_LAST) begin
            kx_d = '0;
            ky_d = ky_q + KW'(1);
          end else begin
            kx_d = kx_q + KW'(1);
          end
          if (tap_q == '0) acc_d = '0;
        end
        if (rvalid_q) acc_d = acc_sum;
        if (last_ret) begin
          out_data_d  = y_sat;
          out_valid_d = 1'b1;
          out_last_d  = (r_q == R_LAST) && (c_q == C_LAST);
          tap_d       = '0;
          kx_d        = '0;
          ky_d        = '0;
        end
      end
      S_EMIT: begin
        if (hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (c_q == C_LAST) begin
            c_d = '0;
            r_d = r_q + RW'(1);
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tap_q       <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      c_q         <= '0;
      r_q         <= '0;
      rvalid_q    <= 1'b0;
      rtap_q      <= '0;
      for (int i = 0; i < KK_I; i++) w_q[i] <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      addr_q      <= '0;
    end else begin
      tap_q       <= tap_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      c_q         <= c_d;
      r_q         <= r_d;
      rvalid_q    <= rvalid_d;
      rtap_q      <= rtap_d;
      for (int i = 0; i < KK_I; i++) w_q[i] <= w_d[i];
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      addr_q      <= addr_d;
    end
  end

endmodule

// File: doc/cnn_conv_engine.md
Name: cnn_conv_engine

Overview:
- Downstream consumer of the CNN parameter/image memory peripheral.
- On start, fetches a KxK signed weight kernel and then slides a valid-mode (no padding) KxK window over an IMG_W x IMG_H unsigned 8-bit image held in that memory.
- For each window: multiply-accumulate, add bias, arithmetic shift, activation/saturation.
- Streams one 8-bit result per window over a valid/ready port in raster order.

Parameters:
- IMG_W, 16, image width in pixels
- IMG_H, 16, image height in pixels
- K, 3, kernel edge; window is K*K taps
- AW, 10, memory address width
- WBASE, 0, address of weight tap 0
- IBASE, 64, address of pixel (0,0)
- ACC_W, 20, signed accumulator width
- SHIFT, 4, arithmetic right shift applied after bias add

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begins a pass when idle
- bias  in  8  signed bias; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final output handshake
- mem_addr  out  AW  memory read address
- mem_rd  out  1  read strobe
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd
- out_data  out  8  result byte
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_last  out  1  high with the final result of a pass

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset_n is synchronous and active-low, sampled on the rising clk edge.
  - While reset_n=0: FSM goes to IDLE; busy, done, mem_rd, out_valid and out_last are 0; out_data and mem_addr are 0; accumulator and counters are cleared.
  - Reset mid-pass aborts the pass with no further outputs.
- FSM states: IDLE, LOAD_W, CONV, EMIT, FIN.
- IDLE:
  - start=1 registers bias, sets busy, goes to LOAD_W.
  - start is ignored in every other state.
- LOAD_W:
  - Issues K*K consecutive reads at WBASE+t, t=0..K*K-1, one per cycle.
  - Captures each returned byte as signed weight w[t] in the cycle it returns.
  - Transitions to CONV in the cycle after the last weight returns.
- CONV, output (r,c):
  - Issues K*K reads in consecutive cycles, tap order ky-major then kx.
  - Tap address: IBASE + (r+ky)*IMG_W + (c+kx).
  - Accumulator is cleared at the first tap; each returned pixel p (zero-extended) adds p*w[t].
  - The cycle after the last tap returns: form y = (acc + sign-extended bias) >>> SHIFT; register out_data and set out_valid; go to EMIT.
  - First tap issued in cycle n gives out_valid high in cycle n+K*K+1 (n+10 for K=3).
- EMIT:
  - out_data, out_valid and out_last hold stable while out_ready=0.
  - No memory reads are issued while in EMIT.
  - On out_valid & out_ready: deassert out_valid.
  - If the handshake is not the last output, the next output's first tap is issued in the following cycle.
  - Outputs are raster order: c increments; c wraps 0 at IMG_W-K+1 with r incrementing. Total (IMG_W-K+1)*(IMG_H-K+1) outputs (196 by default).
  - out_last=1 only for (IMG_H-K, IMG_W-K). Its handshake goes to FIN.
- FIN:
  - done=1 and busy=0 for one cycle, then IDLE.
  - A start in the FIN cycle is ignored.
- Arithmetic:
  - Products are signed 17-bit; sum is ACC_W-bit signed; default widths cannot overflow for K=3.
  - Shift is arithmetic, truncating toward negative infinity.
  - Weights are re-fetched on every pass; the weight memory is not cached across passes.
- mem_rd is high only in read-issue cycles. mem_addr holds its last value otherwise.

Optional Feature:
- Macro: CNN_CONV_RELU_EN.
- Defined: ReLU plus unsigned saturation. y<0 gives 0; y>255 gives 255; otherwise y[7:0].
- Undefined: signed saturation. y<-128 gives 8'h80; y>127 gives 8'h7F; otherwise two's-complement y[7:0].

Test Plan:
- Weights all 1, image all 16, bias 0, default params, RELU_EN defined -> 196 outputs all 9; out_last only on 196th; done pulses once; first output taps read at addresses 64,65,66,80,81,82,96,97,98.
- Weights all 127, image all 255, bias 0 -> acc=291465, y=18216; every output 255 with RELU_EN; 127 (0x7F) without.
- Weights all -1 (0xFF), image all 16, bias 0 -> y=-9; outputs 0 with RELU_EN; 0xF7 without.
- Hold out_ready=0 for 5 cycles while the 3rd output is valid -> out_data and out_valid are stable, mem_rd=0 throughout; 4th output's first tap is read the cycle after the handshake.
- Pulse start repeatedly while busy and in the FIN cycle -> ignored; exactly one pass of 196 outputs completes.
- Drive reset_n=0 for 1 cycle during the 50th output's taps -> next cycle busy, out_valid and mem_rd are 0; a new start reruns the pass from weight fetch at address 0.
